// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - state encoding and command-format constants for the SPI slave register bank
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } spi_state_e;

    localparam int CMD_W  = 8;
    localparam int RW_BIT = 0;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchroniser with rise/fall detection on the 2nd/3rd stages
module spi_sync_edge (
    input  logic clock,
    input  logic n_reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Stages reset low so a select already held low at reset release never looks like a fresh frame start.
    logic [2:0] sync_q;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_regbank.sv
// rtl/spi_slave_regbank.sv - SPI mode 0/2 slave with device-ID header, burst access and a parallel register bank
module spi_slave_regbank
    import spi_slave_pkg::*;
#(
    parameter logic [6:0]        DEV_ID    = 7'h55,
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                NUM_REGS  = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'('h10),
    parameter bit                CPOL      = 1'b0
) (
    input  logic                         clock,
    input  logic                         n_reset,
    input  logic                         ss_i,
    input  logic                         sclk_i,
    input  logic                         mosi_i,
    output logic                         miso_o,
    output logic                         miso_oe_o,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out_o,
    output logic                         wr_strobe_o,
    output logic [ADDR_W-1:0]            wr_addr_o,
    output logic [DATA_W-1:0]            wr_data_o,
    output logic                         busy_o
);

    localparam int AD_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int SH_W   = (AD_MAX > CMD_W) ? AD_MAX : CMD_W;
    localparam int CNT_W  = $clog2(AD_MAX) + 1;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]  REG_SPAN  = (ADDR_W + 1)'(NUM_REGS);

    logic ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_lvl;
    logic ss_lvl_unused, sclk_lvl_unused, mosi_rise_unused, mosi_fall_unused;
    logic sample_evt, launch_evt, phase_last;

    spi_state_e          state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [SH_W-2:0]     shift_q;
    logic [SH_W-1:0]     shift_nxt;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q, addr_inc, addr_rx;
    logic [DATA_W-1:0]   tx_q, word_rx;
    logic                miso_q, miso_oe_q, wr_strobe_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    spi_sync_edge u_sync_ss   (.clock(clock), .n_reset(n_reset), .d_i(ss_i),
                               .level_o(ss_lvl_unused), .rise_o(ss_rise), .fall_o(ss_fall));
    spi_sync_edge u_sync_sclk (.clock(clock), .n_reset(n_reset), .d_i(sclk_i),
                               .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_sync_edge u_sync_mosi (.clock(clock), .n_reset(n_reset), .d_i(mosi_i),
                               .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

    assign sample_evt = CPOL ? sclk_fall : sclk_rise;
    assign launch_evt = CPOL ? sclk_rise : sclk_fall;

    // Offset is one bit wider than the address so BASE_ADDR+NUM_REGS never wraps in the range check.
    function automatic logic [ADDR_W:0] reg_off(input logic [ADDR_W-1:0] a);
        return {1'b0, a} - {1'b0, BASE_ADDR};
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] off;
        off = reg_off(a);
        return !off[ADDR_W] && (off < REG_SPAN);
    endfunction

    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
        return in_range(a) ? regs_q[IDX_W'(reg_off(a))] : '0;
    endfunction

    assign shift_nxt = {shift_q, mosi_lvl};
    assign addr_rx   = shift_nxt[ADDR_W-1:0];
    assign word_rx   = shift_nxt[DATA_W-1:0];
    assign addr_inc  = addr_q + ADDR_W'(1);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_last = 1'b0;
        case (state_q)
            ST_CMD:  phase_last = (bit_cnt_q == CMD_LAST);
            ST_ADDR: phase_last = (bit_cnt_q == ADDR_LAST);
            ST_DATA: phase_last = (bit_cnt_q == DATA_LAST);
            default: phase_last = 1'b0;
        endcase
        if (ss_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (ss_fall) state_d = ST_CMD;
                ST_CMD:  if (sample_evt && phase_last)
                             state_d = (shift_nxt[CMD_W-1:1] == DEV_ID) ? ST_ADDR : ST_IGNORE;
                ST_ADDR: if (sample_evt && phase_last) state_d = ST_DATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (ss_rise) begin
                bit_cnt_q <= '0;
                shift_q   <= '0;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
            end else if (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA) begin
                if (sample_evt) begin
                    shift_q   <= shift_nxt[SH_W-2:0];
                    bit_cnt_q <= phase_last ? '0 : bit_cnt_q + CNT_W'(1);
                    if (phase_last) begin
                        case (state_q)
                            ST_CMD: rw_q <= shift_nxt[RW_BIT];
                            ST_ADDR: begin
                                addr_q <= addr_rx;
                                if (rw_q) tx_q <= rd_word(addr_rx);
                            end
                            default: begin
                                addr_q <= addr_inc;
                                if (rw_q) begin
                                    tx_q <= rd_word(addr_inc);
                                end else begin
                                    wr_strobe_q <= 1'b1;
                                    wr_addr_q   <= addr_q;
                                    wr_data_q   <= word_rx;
                                    if (in_range(addr_q)) regs_q[IDX_W'(reg_off(addr_q))] <= word_rx;
                                end
                            end
                        endcase
                    end
                end else if (launch_evt && state_q == ST_DATA && rw_q) begin
                    miso_q    <= tx_q[DATA_W-1];
                    tx_q      <= {tx_q[DATA_W-2:0], 1'b0};
                    miso_oe_q <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign reg_out_o[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign miso_o      = miso_q;
    assign miso_oe_o   = miso_oe_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: doc/spi_slave_regbank.md
Name: spi_slave_regbank

Overview:
Parametrised SPI slave with an internal register bank, for configuration and status access from an external SPI master. Adds a device-ID command header with an R/W bit, configurable address and data widths, a configurable register count and base address, multi-word burst with address auto-increment, CPOL selection, and a one-cycle write notification port. Sits at the chip boundary; register contents drive the rest of the design through a flat parallel bus.

Parameters:
DEV_ID, 7'h55, device ID matched against command bits [7:1].
ADDR_W, 8, address phase width in bits (4..16).
DATA_W, 8, data word width in bits (8..32).
NUM_REGS, 4, number of implemented registers (1..64).
BASE_ADDR, 8'h10, address of register 0 (ADDR_W bits).
CPOL, 0, sclk idle level. CPHA is fixed at 0: sample on the leading edge, launch on the trailing edge.

Ports:
clock  in  1  system clock; must be at least 8x the sclk frequency.
n_reset  in  1  asynchronous, active-low reset.
ss  in  1  chip select, active low, asynchronous to clock.
sclk  in  1  SPI clock, asynchronous to clock.
mosi  in  1  master-out data, MSB first.
miso  out  1  slave-out data, MSB first.
miso_oe  out  1  miso output enable; 1 only while a read data phase is active.
reg_out  out  NUM_REGS*DATA_W  register contents; register k occupies bits [k*DATA_W +: DATA_W].
wr_strobe  out  1  one-cycle pulse when a register is written.
wr_addr  out  ADDR_W  address of the write; valid while wr_strobe is high.
wr_data  out  DATA_W  data of the write; valid while wr_strobe is high.
busy  out  1  high from ss fall to ss rise, as seen by the synchroniser.

Behaviour:
- Reset: state IDLE; miso=0, miso_oe=0, reg_out all 0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0; all counters and shift registers cleared.
- Synchronisation: ss, sclk and mosi each pass through a 2-FF synchroniser. Edges are detected from the 2nd and 3rd stages.
- Edge definition: sample edge is sclk rising when CPOL=0, falling when CPOL=1. Launch edge is the opposite edge.
- State machine:
  - IDLE -> CMD on ss falling edge.
  - CMD shifts in 8 bits on sample edges. After the 8th bit: if bits[7:1]==DEV_ID go to ADDR and latch rw=bit0 (1=read); otherwise go to IGNORE.
  - ADDR shifts in ADDR_W bits, then goes to DATA.
  - DATA: words of DATA_W bits repeat until ss rises.
  - IGNORE: miso_oe stays 0; all sclk activity is ignored.
- Any state -> IDLE on ss rising edge. This has priority over every other event in the same cycle. A partially received word is discarded and no write occurs.
- Write path (rw=0):
  - One clock after the sample edge that captures the last bit of a word, wr_strobe pulses for 1 cycle with wr_addr=current address and wr_data=the word.
  - If the address is in range (BASE_ADDR <= addr < BASE_ADDR+NUM_REGS), the register updates on that same clock.
  - Out-of-range addresses: wr_strobe still pulses; no register changes.
- Read path (rw=1):
  - The word is loaded into the output shift register at the last sample edge of the ADDR phase or of the previous data word. Out-of-range addresses load 0.
  - MSB is driven on the following launch edge; each subsequent launch edge shifts out the next bit.
  - miso_oe=1 from that first launch edge until ss rises.
- Burst: the address increments by 1 after each complete data word and wraps modulo 2^ADDR_W. Reads snapshot the register at load time.
- Width rules: all counters are sized $clog2(max(ADDR_W,DATA_W))+1 bits. The in-range check uses a subtraction of width ADDR_W+1 (no overflow on the BASE_ADDR+NUM_REGS compare).
- A reset asserted mid-transfer returns to IDLE immediately. The block ignores the rest of the frame until it sees a fresh ss falling edge.

Decomposition:
- Package spi_slave_pkg holds: the state encoding (IDLE, CMD, ADDR, DATA, IGNORE), the RW bit position, and the CMD_W=8 constant.
- One sub-module: spi_sync_edge (2-FF synchroniser plus rise/fall detector, 1-bit), instantiated three times for ss, sclk and mosi.

Test Plan:
- Single write, default params: CMD 0xAA (ID 0x55, W), ADDR 0x11, DATA 0x5C -> one wr_strobe with wr_addr=0x11 and wr_data=0x5C; reg_out[15:8]=0x5C; other registers stay 0.
- Burst read: preload regs 0x10..0x13 = 01,02,03,04; CMD 0xAB, ADDR 0x10, 32 clocks -> miso returns 01 02 03 04 MSB-first; miso_oe=1 only during the data phase.
- Wrong ID: CMD 0x12, ADDR 0x10, DATA 0xFF -> no wr_strobe; miso_oe stays 0; reg_out unchanged.
- Aborted frame: write CMD and ADDR 0x12, then raise ss after 5 data bits -> no wr_strobe; reg 0x12 unchanged. A following full write of 0x77 to 0x12 succeeds.
- Out-of-range and wrap: write to 0x20 -> wr_strobe pulses, reg_out unchanged. Read starting at 0xFF for 2 words -> 0x00, 0x00 (address wraps to 0x00).
- CPOL=1, ADDR_W=16, DATA_W=16: write 0xBEEF to 0x0010 -> reg_out[15:0]=0xBEEF. Then assert n_reset mid-frame -> all outputs return to their reset values.
